// File: rtl/arb_req_client.sv
// ---------------------------------------------------------------------------
// arb_req_client
//
// Requesting client for one input of a fixed-priority arbiter. A job is
// started with start/burst_len in IDLE. The client then raises req, waits for
// ownership (first grant), and consumes burst_len+1 beats. A beat is consumed
// in every XFER cycle where grant is high. One REL cycle with req low follows
// the last beat, and done is pulsed in that cycle.
//
// Optional feature (macro ARB_REQ_CLIENT_TIMEOUT_EN): if the job waits too
// long for its first grant, it is abandoned. The client then goes through REL
// with abort pulsed instead of done.
//
// Parameters
//   BURST_W   width of burst_len (beat count minus one)
//   TIMEOUT   consecutive ungranted WAIT cycles before abort (2..255)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       job request, sampled in IDLE only
//   burst_len   beats minus one, sampled with start
//   req         registered request into the arbiter
//   grant       arbiter grant for this client (combinational from req)
//   beat_valid  XFER & grant: a beat is consumed this cycle
//   busy        high in every state except IDLE
//   done        one-cycle pulse in REL after a completed job
//   abort       one-cycle pulse in REL after a timeout
//   state_dbg   current FSM state (0 IDLE, 1 WAIT, 2 XFER, 3 REL)
//
// Handshake: req is held high from WAIT through the last XFER beat. A cycle
// with req=1 and grant=1 in WAIT transfers ownership and moves no data. A
// cycle with req=1 and grant=1 in XFER moves exactly one beat. grant=0 in XFER
// is preemption: nothing moves, and req stays up.
// ---------------------------------------------------------------------------
module arb_req_client #(
   parameter int BURST_W = 4,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   output logic               req,
   input  logic               grant,
   output logic               beat_valid,
   output logic               busy,
   output logic               done,
   output logic               abort,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_wait = 2'd1,
      st_xfer = 2'd2,
      st_rel  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   // One extra bit so that burst_len = all-ones yields 2^BURST_W without wrapping.
   logic [BURST_W:0] beats, beats_nxt;
   logic             req_nxt;

`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
   logic [7:0]       wcnt, wcnt_nxt;
   logic             rel_abort, rel_abort_nxt;
   logic             timeout_hit;

   assign timeout_hit = (wcnt == 8'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= st_idle;
         beats     <= '0;
         req       <= 1'b0;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
         wcnt      <= '0;
         rel_abort <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         beats     <= beats_nxt;
         req       <= req_nxt;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
         wcnt      <= wcnt_nxt;
         rel_abort <= rel_abort_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      beats_nxt     = beats;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
      wcnt_nxt      = wcnt;
      rel_abort_nxt = rel_abort;
`endif
      case (state)
         st_idle: begin
            if (start) begin
               beats_nxt     = {1'b0, burst_len} + (BURST_W + 1)'(1);
               state_nxt     = st_wait;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
               wcnt_nxt      = '0;
               rel_abort_nxt = 1'b0;
`endif
            end
         end
         st_wait: begin
            if (grant) begin
               state_nxt = st_xfer;
            end
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
            else if (timeout_hit) begin
               state_nxt     = st_rel;
               rel_abort_nxt = 1'b1;
            end else begin
               wcnt_nxt = wcnt + 8'd1;
            end
`endif
         end
         st_xfer: begin
            // Preemption (grant low) simply holds everything.
            if (grant) begin
               beats_nxt = beats - (BURST_W + 1)'(1);
               if (beats == (BURST_W + 1)'(1)) state_nxt = st_rel;
            end
         end
         st_rel: begin
            state_nxt = st_idle;
         end
         default: begin
            state_nxt = st_idle;
         end
      endcase
      // req is registered: it is computed from the state being entered.
      req_nxt = (state_nxt == st_wait) || (state_nxt == st_xfer);
   end

   assign beat_valid = (state == st_xfer) && grant;
   assign busy       = (state != st_idle);
   assign state_dbg  = state;

`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
   assign done  = (state == st_rel) && !rel_abort;
   assign abort = (state == st_rel) &&  rel_abort;
`else
   assign done  = (state == st_rel);
   assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_client.sv
// ---------------------------------------------------------------------------
// tb_arb_req_client
//
// Self-checking bench for arb_req_client. It combines table-driven jobs,
// random jobs checked against a job-level trace model, and hand-written
// sequences for reset, the long wait or timeout case, and three clients
// behind a fixed-priority arbiter.
// ---------------------------------------------------------------------------
module tb_arb_req_client;

   localparam int BURST_W = 4;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [BURST_W-1:0] burst_len;
   logic               req;
   logic               grant;
   logic               beat_valid;
   logic               busy;
   logic               done;
   logic               abort;
   logic [1:0]         state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arb_req_client #(.BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
      .req(req), .grant(grant), .beat_valid(beat_valid), .busy(busy),
      .done(done), .abort(abort), .state_dbg(state_dbg)
   );

   // Three clients behind a 3-bit fixed-priority arbiter (bit 0 highest).
   logic       start3;
   logic [2:0] req3, grant3, bv3, busy3, done3, abort3;
   logic [1:0] st3 [3];

   assign grant3[0] = req3[0];
   assign grant3[1] = req3[1] & ~req3[0];
   assign grant3[2] = req3[2] & ~req3[1] & ~req3[0];

   for (genvar k = 0; k < 3; k++) begin : g_cl
      arb_req_client #(.BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) u_cl (
         .clk(clk), .rst(rst), .start(start3), .burst_len(4'd3),
         .req(req3[k]), .grant(grant3[k]), .beat_valid(bv3[k]),
         .busy(busy3[k]), .done(done3[k]), .abort(abort3[k]),
         .state_dbg(st3[k])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic bit gbit(input logic [63:0] p, input int i);
      return (i < 64) ? p[i] : 1'b1;
   endfunction

   // Runs one job. The grant seen in cycle i after start is gpat[i]; from
   // cycle 64 onward grant is 1. The expected trace comes from the job
   // rules:
   //   - the first grant g0 gives ownership;
   //   - each later granted cycle is one beat;
   //   - the cycle after the final beat is the release cycle.
   task automatic run_job(input logic [BURST_W-1:0] blen, input logic [63:0] gpat,
                          input bit rnd_start, output int o_req, output int o_bv,
                          output int o_done, output int o_abort);
      int g0, klast, relc, cnt;
      bit aborted;
      bit e_req, e_bv, e_done, e_abort;
      g0 = 64;
      for (int i = 63; i >= 0; i--) if (gpat[i]) g0 = i;
      aborted = 1'b0;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
      if (g0 >= TIMEOUT) aborted = 1'b1;
`endif
      if (aborted) begin
         klast = TIMEOUT - 1;
         relc  = TIMEOUT;
      end else begin
         cnt   = 0;
         klast = g0;
         for (int i = g0 + 1; cnt < int'(blen) + 1; i++) begin
            if (gbit(gpat, i)) cnt++;
            klast = i;
         end
         relc = klast + 1;
      end
      o_req = 0; o_bv = 0; o_done = -1; o_abort = -1;
      // Cycle in IDLE that carries start.
      @(posedge clk); #1;
      start = 1'b1; burst_len = blen; grant = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_req", req, 0);
      chk("idle_bv", beat_valid, 0);
      for (int i = 0; i <= relc; i++) begin
         @(posedge clk); #1;
         start     = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
         burst_len = BURST_W'($urandom);
         grant     = gbit(gpat, i);
         @(negedge clk);
         e_req   = (i <= klast);
         e_bv    = !aborted && (i > g0) && (i <= klast) && gbit(gpat, i);
         e_done  = !aborted && (i == relc);
         e_abort = aborted && (i == relc);
         chk("req", req, e_req);
         chk("beat_valid", beat_valid, e_bv);
         chk("done", done, e_done);
         chk("abort", abort, e_abort);
         chk("busy", busy, 1);
         if (req) o_req++;
         if (beat_valid) o_bv++;
         if (done && o_done < 0) o_done = i;
         if (abort && o_abort < 0) o_abort = i;
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic [BURST_W-1:0] blen;
      logic [63:0]        gpat;
      int                 exp_req;
      int                 exp_bv;
      int                 exp_done;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int r_req, r_bv, r_done, r_abort;
      int first_done [3];
      int nbeat [3];
      int overlap, seen_abort, seen_bv, rise, bv_before;
      logic [BURST_W-1:0] rb;

      vecs[0] = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5,  4,  5};   // uncontended
      vecs[1] = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 2,  1,  2};   // single beat
      vecs[2] = '{4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 17, 16, 17};  // max burst, no wrap
      vecs[3] = '{4'd2,  64'hFFFF_FFFF_FFFF_FFE3, 7,  3,  7};   // 3-cycle preemption
      vecs[4] = '{4'd1,  64'hFFFF_FFFF_FFFF_FFE0, 8,  2,  8};   // late first grant
      vecs[5] = '{4'd4,  64'h5555_5555_5555_5555, 11, 5,  11};  // alternating grant

      // Clock/reset.
      rst = 1'b1; start = 1'b0; burst_len = '0; grant = 1'b0; start3 = 1'b0;
      #1;
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_abort", abort, 0);
      chk("rst_state", state_dbg, 0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Table-driven jobs, issued back to back.
      for (int v = 0; v < 6; v++) begin
         run_job(vecs[v].blen, vecs[v].gpat, 1'b1, r_req, r_bv, r_done, r_abort);
         chk($sformatf("vec%0d_req_cycles", v), r_req, vecs[v].exp_req);
         chk($sformatf("vec%0d_beats", v), r_bv, vecs[v].exp_bv);
         chk($sformatf("vec%0d_done_cycle", v), r_done, vecs[v].exp_done);
         chk($sformatf("vec%0d_no_abort", v), r_abort, -1);
      end

      // Random jobs checked against the trace model.
      for (int n = 0; n < 25; n++) begin
         rb = BURST_W'($urandom);
         run_job(rb, {$urandom, $urandom}, 1'b1, r_req, r_bv, r_done, r_abort);
      end

      // Reset in the middle of an 8-beat transfer.
      @(posedge clk); #1;
      start = 1'b1; burst_len = 4'd7; grant = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bv_before = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (beat_valid) bv_before++;
         @(posedge clk); #1;
      end
      chk("pre_rst_beats", bv_before, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_req", req, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_bv", beat_valid, 0);
      chk("midrst_done", done, 0);
      @(negedge clk);
      chk("midrst_done_hold", done, 0);
      chk("midrst_abort_hold", abort, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      run_job(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r_req, r_bv, r_done, r_abort);
      chk("postrst_beats", r_bv, 8);
      chk("postrst_done_cycle", r_done, 9);

`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
      // No grant at all: abort 16 cycles after req rises.
      @(posedge clk); #1;
      start = 1'b1; burst_len = 4'd3; grant = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      seen_abort = -1; seen_bv = 0; rise = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (req && rise < 0) rise = i;
         if (beat_valid) seen_bv++;
         if (abort && seen_abort < 0) begin
            seen_abort = i;
            chk("to_req_in_rel", req, 0);
            chk("to_done_low", done, 0);
         end
         @(posedge clk); #1;
      end
      chk("to_abort_latency", seen_abort - rise, 16);
      chk("to_no_beats", seen_bv, 0);
      chk("to_idle_after", busy, 0);
`else
      // No grant for 100 cycles: the job keeps waiting, then completes.
      @(posedge clk); #1;
      start = 1'b1; burst_len = 4'd1; grant = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      seen_abort = 0; rise = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req) rise++;
         if (abort) seen_abort++;
         @(posedge clk); #1;
      end
      chk("nto_req_high_cycles", rise, 100);
      chk("nto_abort_count", seen_abort, 0);
      grant = 1'b1;
      r_done = -1; seen_bv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (beat_valid) seen_bv++;
         if (done && r_done < 0) r_done = i;
         @(posedge clk); #1;
      end
      chk("nto_beats", seen_bv, 2);
      chk("nto_done_cycle", r_done, 3);
      chk("nto_idle_after", busy, 0);
`endif
      grant = 1'b0;

      // Three clients started together behind the priority arbiter.
      @(posedge clk); #1;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      overlap = 0;
      for (int k = 0; k < 3; k++) begin first_done[k] = -1; nbeat[k] = 0; end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if ((bv3 & (bv3 - 3'd1)) != 3'd0) overlap++;
         for (int k = 0; k < 3; k++) begin
            if (bv3[k]) nbeat[k]++;
            if (done3[k] && first_done[k] < 0) first_done[k] = c;
         end
      end
      chk("arb3_overlap", overlap, 0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("arb3_beats%0d", k), nbeat[k], 4);
         chk($sformatf("arb3_done_cycle%0d", k), first_done[k], 5 * (k + 1));
         chk($sformatf("arb3_abort%0d", k), abort3[k], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb_req_client.md
ARB_REQ_CLIENT -- requirements
Module: arb_req_client

Interface
REQ-001 Parameter BURST_W, default 4, SHALL set the width of burst_len.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the number of consecutive ungranted WAIT cycles before abort (range 2..255).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-005 Port start, input, 1, SHALL request one job; sampled in IDLE only.
REQ-006 Port burst_len, input, BURST_W, SHALL give the beat count minus one; sampled with start.
REQ-007 Port req, output, 1, SHALL be this client's request line into one req bit of the fixed-priority arbiter.
REQ-008 Port grant, input, 1, SHALL be the matching grant bit from the arbiter; treated as combinational from req.
REQ-009 Port beat_valid, output, 1, SHALL mark a cycle in which this client owns the resource and a beat is consumed.
REQ-010 Port busy, output, 1, SHALL be high in every state except IDLE.
REQ-011 Port done, output, 1, SHALL pulse one cycle on successful completion.
REQ-012 Port abort, output, 1, SHALL pulse one cycle on timeout.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, XFER and REL; encoding is free.
REQ-014 IDLE: start=1 SHALL latch burst_len+1 into beat counter BEATS (BURST_W+1 bits) and go to WAIT.
REQ-015 start SHALL be ignored in WAIT, XFER and REL (no queueing, no latch update).
REQ-016 req SHALL be a registered output, high in WAIT and XFER and low in IDLE and REL.
REQ-017 Latency: start high at edge n SHALL give req high from edge n+1.
REQ-018 WAIT: grant=1 SHALL move to XFER with no beat consumed; grant=0 SHALL increment wait counter WCNT.
REQ-019 XFER: beat_valid SHALL equal grant (combinational AND with state XFER); each beat_valid cycle SHALL decrement BEATS by 1.
REQ-020 XFER: grant=0 (preemption by a higher-priority requester) SHALL hold BEATS, keep req high and remain in XFER; WCNT is not used in XFER.
REQ-021 XFER: a beat with BEATS==1 SHALL be the last beat and SHALL move to REL.
REQ-022 REL SHALL last exactly one cycle with req=0, SHALL drive done=1 (or abort=1 when entered from timeout), then return to IDLE.
REQ-023 burst_len=0 SHALL give exactly one beat; burst_len=2^BURST_W-1 SHALL give 2^BURST_W beats with no counter wrap.
REQ-024 done and abort SHALL never be high in the same cycle.
REQ-025 A back-to-back start SHALL be accepted no earlier than the cycle after REL, giving at least one req-low cycle between jobs.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, req=0, busy=0, done=0, abort=0, BEATS=0 and WCNT=0, regardless of clk.
REQ-027 rst asserted mid-XFER SHALL drop req and beat_valid in the same cycle, with no done or abort pulse.
REQ-028 After rst deasserts, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-029 With macro ARB_REQ_CLIENT_TIMEOUT_EN defined, WCNT reaching TIMEOUT-1 in WAIT with grant=0 SHALL move to REL with abort pulsed and done low.
REQ-030 Without ARB_REQ_CLIENT_TIMEOUT_EN, WCNT SHALL be omitted, WAIT SHALL wait indefinitely and abort SHALL be tied to 0.

Verification
REQ-031 Scenario uncontended: grant tied to req, start with burst_len=3 -> req high for 5 cycles (1 WAIT + 4 XFER), 4 beat_valid, done pulse in REL, busy low after.
REQ-032 Scenario preemption: burst_len=2, grant deasserted for 3 cycles after the first beat -> exactly 3 beat_valid total, req held high through the gap, single done pulse.
REQ-033 Scenario timeout (macro defined, TIMEOUT=16): start, grant held 0 -> abort pulse exactly 16 cycles after req rises, req low in REL, no beat_valid.
REQ-034 Scenario no timeout (macro undefined): grant held 0 for 100 cycles -> req stays high, abort stays 0; grant then 1 -> job completes normally.
REQ-035 Scenario reset mid-transfer: rst pulsed after 2 of 8 beats -> req, busy and beat_valid low immediately, no done; a new start then completes all of its beats.
REQ-036 Scenario with three instances on the 3-bit fixed-priority arbiter and all started together -> the highest-priority client completes first, no two beat_valid high in the same cycle, every client gets its done.
